// File: rtl/dma_axi_sched_pkg.sv
// Shared constants and FSM encoding for the descriptor-driven AXI burst scheduler.
package dma_axi_sched_pkg;

  localparam int BOUNDARY_BYTES = 4096;
  localparam int PAGE_OFF_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_WAIT,
    ST_XFER,
    ST_FIN
  } state_t;

  function automatic int beat_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dma_axi_sched_burst_calc.sv
// Combinational burst sizer: min(remaining, MAX_BURST, beats left before the next 4 KB boundary).
module dma_axi_sched_burst_calc
  import dma_axi_sched_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 256,
  parameter int BEAT_W    = 9
) (
  input  logic [PAGE_OFF_W-1:0] page_off,
  input  logic [CNT_W-1:0]      remaining,
  output logic [BEAT_W-1:0]     beats
);

  localparam int SHIFT = beat_shift(DATA_W);

  logic [PAGE_OFF_W:0] room_bytes;
  logic [31:0]         room_w;
  logic [31:0]         pick;

  always_comb begin
    room_bytes = (PAGE_OFF_W + 1)'(BOUNDARY_BYTES) - {1'b0, page_off};
    room_w     = 32'(room_bytes >> SHIFT);
    pick       = 32'(remaining);
    if (room_w < pick)
      pick = room_w;
    if (32'(MAX_BURST) < pick)
      pick = 32'(MAX_BURST);
    beats = BEAT_W'(pick);
  end

endmodule

// File: rtl/dma_axi_sched.sv
// Splits one DMA command into AXI-legal bursts and moves beats between the streams and dma_axi's native port.
module dma_axi_sched
  import dma_axi_sched_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [CNT_W-1:0]    cmd_words,
  input  logic                cmd_write,
  output logic                busy,
  output logic                done,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  output logic                m_valid,
  output logic [DATA_W-1:0]   m_data,
  input  logic                m_ready,
  output logic                dma_valid,
  output logic [ADDR_W-1:0]   dma_address,
  output logic [DATA_W-1:0]   dma_wdata,
  output logic [DATA_W/8-1:0] dma_wstrb,
  input  logic [DATA_W-1:0]   dma_rdata,
  input  logic                dma_rvalid,
  output logic [LEN_W-1:0]    dma_len,
  input  logic                dma_ready
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  state_t              state;
  logic [ADDR_W-1:0]   addr_r;
  logic [CNT_W-1:0]    rem_r;
  logic                write_r;
  logic [BEAT_W-1:0]   bcnt;
  logic [BEAT_W-1:0]   beats;
  logic                xfer;
  logic                beat;

  dma_axi_sched_burst_calc #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .MAX_BURST (MAX_BURST),
    .BEAT_W    (BEAT_W)
  ) u_calc (
    .page_off  (addr_r[PAGE_OFF_W-1:0]),
    .remaining (rem_r),
    .beats     (beats)
  );

  assign xfer        = (state == ST_XFER);
  assign beat        = dma_valid & dma_rvalid;
  assign cmd_ready   = (state == ST_IDLE);
  assign dma_address = addr_r;

  // Reads only request a beat when the single output slot is free or emptying this cycle.
  always_comb begin
    dma_valid = 1'b0;
    s_ready   = 1'b0;
    dma_wdata = '0;
    dma_wstrb = '0;
    if (xfer) begin
      if (write_r) begin
        dma_valid = s_valid;
        s_ready   = s_valid & dma_rvalid;
        dma_wdata = s_data;
        dma_wstrb = '1;
      end else begin
        dma_valid = ~m_valid | m_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_r  <= '0;
      rem_r   <= '0;
      write_r <= 1'b0;
      bcnt    <= '0;
      dma_len <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      // Output slot reloads on a new beat even when it is being drained in the same cycle.
      if (!write_r && beat) begin
        m_valid <= 1'b1;
        m_data  <= dma_rdata;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_r  <= cmd_addr;
            rem_r   <= cmd_words;
            write_r <= cmd_write;
            busy    <= 1'b1;
            state   <= (cmd_words == '0) ? ST_FIN : ST_CALC;
          end
        end
        ST_CALC: begin
          dma_len <= LEN_W'(beats - 1'b1);
          bcnt    <= beats;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dma_ready)
            state <= ST_XFER;
        end
        ST_XFER: begin
          if (beat) begin
            addr_r <= addr_r + ADDR_W'(BYTES);
            rem_r  <= rem_r - 1'b1;
            bcnt   <= bcnt - 1'b1;
            if (bcnt == BEAT_W'(1))
              state <= (rem_r != CNT_W'(1)) ? ST_CALC : ST_FIN;
          end
        end
        ST_FIN: begin
          if (write_r || !m_valid || m_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_axi_sched.sv
// Directed bench for dma_axi_sched with a simple native-port responder and stream models.
module tb_dma_axi_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_words = '0;
  logic        cmd_write = 1'b0;
  logic        busy, done;
  logic        s_valid = 1'b0;
  logic [31:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        dma_valid;
  logic [31:0] dma_address, dma_wdata, dma_rdata;
  logic [3:0]  dma_wstrb;
  logic        dma_rvalid;
  logic [7:0]  dma_len;
  logic        dma_ready = 1'b1;

  logic        mr_fix = 1'b1;
  logic        tog = 1'b0;
  logic        tog_ph = 1'b0;
  int          s_idx = 0;
  int          done_cnt = 0;
  int          stall_cyc = 0;
  int          viol = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] q_addr[$];
  logic [7:0]  q_len[$];
  logic [31:0] q_wd[$];
  logic [31:0] q_m[$];

  always #5 clk = ~clk;

  assign m_ready    = tog ? tog_ph : mr_fix;
  assign dma_rvalid = dma_valid;
  assign dma_rdata  = dma_address ^ 32'h5A5A_0000;
  assign s_data     = 32'h1000 + s_idx;

  dma_axi_sched dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_words(cmd_words), .cmd_write(cmd_write),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .dma_valid(dma_valid), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dma_len(dma_len), .dma_ready(dma_ready)
  );

  always @(negedge clk) if (tog) tog_ph = ~tog_ph;

  always @(posedge clk) begin
    if (!rst) begin
      if (dma_valid && dma_rvalid) begin
        q_addr.push_back(dma_address);
        q_len.push_back(dma_len);
        q_wd.push_back(dma_wdata);
      end
      if (m_valid && m_ready) q_m.push_back(m_data);
      if (done) done_cnt++;
      if (s_valid && s_ready) s_idx++;
      if (busy && m_valid && !m_ready) begin
        stall_cyc++;
        if (dma_valid) viol++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_addr.delete(); q_len.delete(); q_wd.delete(); q_m.delete();
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] w, input logic wr);
    cmd_addr = a; cmd_words = w; cmd_write = wr; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(done_cnt - start), 64'd1);
  endtask

  initial begin
    int c255, c87;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dma_valid", 64'(dma_valid), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_dma_len", 64'(dma_len), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 4-beat write burst, held in WAIT until dma_ready
    clear_q();
    dma_ready = 1'b0;
    s_valid = 1'b1;
    issue(32'h0, 16'd4, 1'b1);
    repeat (3) @(negedge clk);
    check("t1_wait_no_valid", 64'(dma_valid), 64'd0);
    check("t1_wait_busy", 64'(busy), 64'd1);
    check("t1_wait_len", 64'(dma_len), 64'd3);
    dma_ready = 1'b1;
    wait_done("t1_done", 50);
    s_valid = 1'b0;
    check("t1_beats", 64'(q_addr.size()), 64'd4);
    if (q_addr.size() == 4) begin
      check("t1_addr0", 64'(q_addr[0]), 64'h0);
      check("t1_addr1", 64'(q_addr[1]), 64'h4);
      check("t1_addr2", 64'(q_addr[2]), 64'h8);
      check("t1_addr3", 64'(q_addr[3]), 64'hC);
      check("t1_len3", 64'(q_len[3]), 64'd3);
      check("t1_wd0", 64'(q_wd[0]), 64'h1000);
      check("t1_wd3", 64'(q_wd[3]), 64'h1003);
    end
    check("t1_s_handshakes", 64'(s_idx), 64'd4);
    @(negedge clk);
    check("t1_done_one_cycle", 64'(done), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // Read across a 4 KB boundary, with a command attempt while busy
    clear_q();
    issue(32'hFF8, 16'd4, 1'b0);
    cmd_addr = 32'h40; cmd_words = 16'd5; cmd_valid = 1'b1;
    check("t2_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("t2_done", 50);
    check("t2_beats", 64'(q_addr.size()), 64'd4);
    if (q_addr.size() == 4) begin
      check("t2_addr1", 64'(q_addr[1]), 64'hFFC);
      check("t2_addr2", 64'(q_addr[2]), 64'h1000);
      check("t2_len0", 64'(q_len[0]), 64'd1);
      check("t2_len2", 64'(q_len[2]), 64'd1);
    end
    check("t2_words", 64'(q_m.size()), 64'd4);
    if (q_m.size() == 4) begin
      check("t2_m0", 64'(q_m[0]), 64'h5A5A0FF8);
      check("t2_m1", 64'(q_m[1]), 64'h5A5A0FFC);
      check("t2_m2", 64'(q_m[2]), 64'h5A5A1000);
      check("t2_m3", 64'(q_m[3]), 64'h5A5A1004);
    end

    // 600 beats: 256 + 256 + 88
    clear_q();
    s_valid = 1'b1;
    issue(32'h0, 16'd600, 1'b1);
    wait_done("t3_done", 2000);
    s_valid = 1'b0;
    check("t3_beats", 64'(q_addr.size()), 64'd600);
    c255 = 0; c87 = 0;
    foreach (q_len[i]) begin
      if (q_len[i] == 8'd255) c255++;
      if (q_len[i] == 8'd87) c87++;
    end
    check("t3_full_beats", 64'(c255), 64'd512);
    check("t3_tail_beats", 64'(c87), 64'd88);
    if (q_addr.size() == 600) begin
      check("t3_addr256", 64'(q_addr[256]), 64'h400);
      check("t3_addr599", 64'(q_addr[599]), 64'h95C);
      check("t3_len512", 64'(q_len[512]), 64'd87);
    end

    // Zero-word command
    clear_q();
    issue(32'h123C, 16'd0, 1'b1);
    check("t4_no_done_yet", 64'(done), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t4_done", 64'(done), 64'd1);
    check("t4_busy_clear", 64'(busy), 64'd0);
    check("t4_no_beats", 64'(q_addr.size()), 64'd0);

    // Read with a toggling consumer
    clear_q();
    stall_cyc = 0; viol = 0;
    tog = 1'b1;
    issue(32'h100, 16'd6, 1'b0);
    wait_done("t5_done", 100);
    tog = 1'b0;
    check("t5_words", 64'(q_m.size()), 64'd6);
    if (q_m.size() == 6)
      for (int i = 0; i < 6; i++)
        check($sformatf("t5_m%0d", i), 64'(q_m[i]), 64'(32'h5A5A0100 + 32'(4 * i)));
    check("t5_stall_seen", 64'(stall_cyc > 0), 64'd1);
    check("t5_no_overrun", 64'(viol), 64'd0);
    @(negedge clk);
    check("t5_drained", 64'(m_valid), 64'd0);

    // Reset mid-burst
    clear_q();
    s_valid = 1'b1;
    issue(32'h200, 16'd8, 1'b1);
    for (int n = 0; n < 50 && q_addr.size() < 2; n++) @(negedge clk);
    check("t6_two_beats", 64'(q_addr.size()), 64'd2);
    c255 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_dma_valid", 64'(dma_valid), 64'd0);
    check("t6_s_ready", 64'(s_ready), 64'd0);
    check("t6_dma_address", 64'(dma_address), 64'h0);
    check("t6_dma_len", 64'(dma_len), 64'h0);
    check("t6_wdata_wstrb", {28'h0, dma_wstrb, dma_wdata}, 64'h0);
    check("t6_m_data", 64'(m_data), 64'h0);
    rst = 1'b0;
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_done", 64'(done_cnt), 64'(c255));
    check("t6_stays_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
